ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_tx_if.sv | 29 ++
 rtl/ps2_clk_filter.sv | 54 +++++
 rtl/ps2_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter.
//   state_t          : transmitter FSM state encoding
//   RTS_CYCLES_DEF   : default request-to-send hold time in clk cycles
//   FILTER_LEN_DEF   : default ps2c deglitch filter length in samples
//   odd_parity()     : PS/2 parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam int RTS_CYCLES_DEF = 10000;
    localparam int FILTER_LEN_DEF = 8;

    // PS/2 uses odd parity: the parity bit makes the total count of ones
    // across data plus parity odd, i.e. it is the XNOR-reduce of the byte.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if -- host-side handshake between a byte producer and ps2_tx.
//   wr_ps2       : single-cycle write strobe (producer -> transmitter)
//   din          : byte to transmit (producer -> transmitter)
//   tx_idle      : transmitter idle and ready for a write
//   tx_done_tick : one-cycle pulse when a frame has completed
interface ps2_tx_if;

    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;

    // Producer side.
    modport master (
        output wr_ps2,
        output din,
        input  tx_idle,
        input  tx_done_tick
    );

    // Transmitter side.
    modport slave (
        input  wr_ps2,
        input  din,
        output tx_idle,
        output tx_done_tick
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter -- deglitches the sampled PS/2 clock pad and reports its
// falling edges.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high
//   ps2c_in   : raw sampled PS/2 clock line
//   fall_edge : one-cycle pulse when the filtered level goes 1 -> 0
// The filtered level only changes after FILTER_LEN identical samples, so a
// shorter pulse in either direction is ignored.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic [FILTER_LEN:0]   filt_ext_s;
    logic                  level_q, level_d;
    logic                  fall_q, fall_d;

    // Shift in the new sample, update the hysteretic level and detect 1 -> 0.
    always_comb begin
        filt_ext_s = {ps2c_in, filt_q};
        filt_d     = filt_ext_s[FILTER_LEN:1];
        if (filt_d == {FILTER_LEN{1'b1}}) begin
            level_d = 1'b1;
        end else if (filt_d == {FILTER_LEN{1'b0}}) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        fall_d = level_q & ~level_d;
    end

    // Filter state registers; the line idles high, so reset to all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q  <= {FILTER_LEN{1'b1}};
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_edge = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx -- PS/2 host-to-device byte transmitter.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   host     : ps2_tx_if.slave (wr_ps2, din in; tx_idle, tx_done_tick out)
//   ps2c_in  : sampled PS/2 clock pad
//   ps2c_out : PS/2 clock drive value (always 0, enabled by tri_c)
//   tri_c    : 1 = pull the clock line low (request-to-send only)
//   ps2d_out : PS/2 data drive value
//   tri_d    : 1 = drive ps2d_out onto the data line, 0 = release
// Frame: hold clock low for RTS_CYCLES, release it with data low (start bit),
// then present d0..d7 and odd parity, advancing on each device falling edge,
// release data for the stop bit and finish on the following falling edge.
// All line enables and status outputs are registered copies of values
// computed from the next state, so they line up with the state register;
// tx_done_tick is therefore seen in the first idle cycle after the frame.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES = RTS_CYCLES_DEF,
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ps2_tx_if.slave        host,
    input  logic           ps2c_in,
    output logic           ps2c_out,
    output logic           tri_c,
    output logic           ps2d_out,
    output logic           tri_d
);

    localparam int CNT_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [8:0]         shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic               tri_c_q, tri_c_d;
    logic               tri_d_q, tri_d_d;
    logic               ps2d_q, ps2d_d;
    logic               idle_q, idle_d;
    logic               done_q, done_d;
    logic               fall_edge_s;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .fall_edge (fall_edge_s)
    );

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.wr_ps2) begin
                    shift_d = {odd_parity(host.din), host.din};
                    cnt_d   = CNT_W'(RTS_CYCLES - 1);
                    state_d = ST_RTS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RTS: begin
                // Counter runs RTS_CYCLES-1 down to 0: RTS_CYCLES cycles total.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            ST_START: begin
                if (fall_edge_s) begin
                    bit_d   = 4'd8;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (fall_edge_s) begin
                    shift_d = {1'b0, shift_q[8:1]};
                    if (bit_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (fall_edge_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tri_c_d = (state_d == ST_RTS);
        tri_d_d = (state_d == ST_START) || (state_d == ST_DATA);
        ps2d_d  = (state_d == ST_DATA) ? shift_d[0] : 1'b0;
        idle_d  = (state_d == ST_IDLE);
    end

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= 9'd0;
            cnt_q   <= {CNT_W{1'b0}};
            bit_q   <= 4'd0;
            tri_c_q <= 1'b0;
            tri_d_q <= 1'b0;
            ps2d_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tri_c_q <= tri_c_d;
            tri_d_q <= tri_d_d;
            ps2d_q  <= ps2d_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
        end
    end

    assign ps2c_out          = 1'b0;
    assign tri_c             = tri_c_q;
    assign tri_d             = tri_d_q;
    assign ps2d_out          = ps2d_q;
    assign host.tx_idle      = idle_q;
    assign host.tx_done_tick = done_q;

endmodule
